// File: rtl/fall_scan_controller.sv
// Round-robin scan of N_CH sensor channels through one shared falling detector, with per-channel
// debounce, pending alarms and an irq/ack handshake. Define FALL_THRESH_CFG_EN for per-channel thresholds.
module fall_scan_controller #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned SCAN_GAP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [8*N_CH-1:0]   sensor_bus,
    input  logic [7:0]          factory_value,
`ifdef FALL_THRESH_CFG_EN
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [7:0]          cfg_data,
`endif
    output logic [7:0]          cmp_sensor,
    output logic [7:0]          cmp_factory,
    input  logic                cmp_fall,
    output logic                busy,
    output logic                irq,
    output logic [3:0]          alarm_ch,
    input  logic                alarm_ack,
    output logic [N_CH-1:0]     pending
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_ch, w_ch_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [CNT_W-1:0]   r_cnt [N_CH];
    logic [N_CH-1:0]    r_pending, w_pend_nxt;
    logic [CH_W-1:0]    w_idx, w_alarm_idx;
    logic [7:0]         w_ch_val [N_CH];
    logic [CNT_W-1:0]   w_cnt_cur, w_cnt_nxt;
    logic               w_sample, w_set;

    assign w_idx = r_ch[CH_W-1:0];

    // Channel unpack and comparator drive
    always_comb begin
        for (int k = 0; k < int'(N_CH); k++) begin
            w_ch_val[k] = sensor_bus[8*k +: 8];
        end
    end

    assign cmp_sensor = w_ch_val[w_idx];

`ifdef FALL_THRESH_CFG_EN
    logic [7:0] r_thr [N_CH];
    logic       w_cfg_hit;

    assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < 5'(N_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                r_thr[k] <= 8'hFF;
            end
        end else if (w_cfg_hit) begin
            r_thr[cfg_ch[CH_W-1:0]] <= cfg_data;
        end
    end

    assign cmp_factory = r_thr[w_idx];
`else
    assign cmp_factory = factory_value;
`endif

    // Scan sequencing: DRIVE/SAMPLE per channel, then a gap of max(SCAN_GAP,1) cycles
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_gap_nxt   = r_gap;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scan_en) begin
                    w_state_nxt = S_DRIVE;
                    w_ch_nxt    = 4'd0;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
                if (!scan_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_ch == 4'(N_CH - 1)) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_W'(SCAN_GAP);
                end else begin
                    w_state_nxt = S_DRIVE;
                    w_ch_nxt    = r_ch + 4'd1;
                end
            end
            S_GAP: begin
                if (!scan_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap <= GAP_W'(1)) begin
                    w_state_nxt = S_DRIVE;
                    w_ch_nxt    = 4'd0;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Debounce update; only the DEBOUNCE-1 -> DEBOUNCE step raises an alarm
    always_comb begin
        w_cnt_cur = r_cnt[w_idx];
        w_cnt_nxt = '0;
        w_set     = 1'b0;
        if (cmp_fall) begin
            w_cnt_nxt = (w_cnt_cur >= CNT_W'(DEBOUNCE)) ? CNT_W'(DEBOUNCE) : w_cnt_cur + CNT_W'(1);
            w_set     = (w_cnt_cur == CNT_W'(DEBOUNCE - 1));
        end
    end

    // Lowest pending channel wins
    always_comb begin
        w_alarm_idx = '0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_alarm_idx = CH_W'(k);
            end
        end
    end

    // Ack clears first so a same-cycle set on that channel survives
    always_comb begin
        w_pend_nxt = r_pending;
        if (alarm_ack && (|r_pending)) begin
            w_pend_nxt[w_alarm_idx] = 1'b0;
        end
        if (w_sample && w_set) begin
            w_pend_nxt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ch      <= 4'd0;
            r_gap     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_gap     <= w_gap_nxt;
            r_pending <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_sample) begin
            r_cnt[w_idx] <= w_cnt_nxt;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign irq      = |r_pending;
    assign pending  = r_pending;
    assign alarm_ch = 4'(w_alarm_idx);

endmodule

// File: tb/tb_fall_scan_controller.sv
// Bench for fall_scan_controller: round table, hand sequences and randomized scan against a
// schedule-level model (phase within a round derived arithmetically from cycles since start).
module tb_fall_scan_controller;

    localparam int N   = 4;
    localparam int D   = 3;
    localparam int GAP = 8;
    localparam int R   = 2*N + ((GAP > 1) ? GAP : 1);

    localparam logic [7:0] L = 8'd50;
    localparam logic [7:0] H = 8'd120;
    localparam logic [7:0] E = 8'd100;
    localparam logic [7:0] B = 8'd99;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           scan_en;
    logic [8*N-1:0] sensor_bus;
    logic [7:0]     factory_value;
    logic [7:0]     cmp_sensor, cmp_factory;
    logic           cmp_fall;
    logic           busy, irq, alarm_ack;
    logic [3:0]     alarm_ch;
    logic [N-1:0]   pending;
`ifdef FALL_THRESH_CFG_EN
    logic           cfg_we;
    logic [3:0]     cfg_ch;
    logic [7:0]     cfg_data;
`endif

    always #5 clk = ~clk;

    // External detector: high when sensor >= threshold
    assign cmp_fall = (cmp_sensor >= cmp_factory);

    fall_scan_controller #(.N_CH(N), .DEBOUNCE(D), .SCAN_GAP(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_en       (scan_en),
        .sensor_bus    (sensor_bus),
        .factory_value (factory_value),
`ifdef FALL_THRESH_CFG_EN
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_data      (cfg_data),
`endif
        .cmp_sensor    (cmp_sensor),
        .cmp_factory   (cmp_factory),
        .cmp_fall      (cmp_fall),
        .busy          (busy),
        .irq           (irq),
        .alarm_ch      (alarm_ch),
        .alarm_ack     (alarm_ack),
        .pending       (pending)
    );

    typedef struct {
        logic [31:0] bus;
        int          ack_ph;
        logic [3:0]  exp_pend;
        logic [3:0]  exp_ach;
    } row_t;

    row_t rows[$];
    int   n_vec = 0;
    int   n_bad = 0;

    bit           m_run;
    int           m_cyc;
    int           m_cnt [N];
    logic [N-1:0] m_pend;
    logic [7:0]   m_thr [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] p);
        for (int i = 0; i < N; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] thr_of(input int k, input logic [7:0] fv);
`ifdef FALL_THRESH_CFG_EN
        return m_thr[k];
`else
        return fv;
`endif
    endfunction

    task automatic model_clear();
        m_run  = 1'b0;
        m_cyc  = 0;
        m_pend = '0;
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            m_thr[k] = 8'hFF;
        end
    endtask

    // One clock: capture inputs, advance the model at the edge, check outputs #1 later
    task automatic tick();
        bit          en, ack;
        logic [31:0] bus;
        logic [7:0]  fv, thr;
        int          ph, k;
`ifdef FALL_THRESH_CFG_EN
        bit          we;
        logic [3:0]  cc;
        logic [7:0]  cd;
        we = cfg_we; cc = cfg_ch; cd = cfg_data;
`endif
        en = scan_en; ack = alarm_ack; bus = sensor_bus; fv = factory_value;
        @(posedge clk);
        if (ack && m_pend != '0) m_pend[lowest(m_pend)] = 1'b0;
        if (m_run) begin
            ph = m_cyc % R;
            if (ph < 2*N && ph % 2 == 1) begin
                k   = ph / 2;
                thr = thr_of(k, fv);
                if (bus[8*k +: 8] >= thr) begin
                    if (m_cnt[k] == D - 1) m_pend[k] = 1'b1;
                    if (m_cnt[k] < D) m_cnt[k]++;
                end else begin
                    m_cnt[k] = 0;
                end
                if (!en) m_run = 1'b0;
            end else if (ph >= 2*N && !en) begin
                m_run = 1'b0;
            end
            m_cyc++;
        end else if (en) begin
            m_run = 1'b1;
            m_cyc = 0;
        end
`ifdef FALL_THRESH_CFG_EN
        if (we && cc < 4'(N)) m_thr[cc] = cd;
`endif
        #1;
        chk("busy", 32'(busy), 32'(m_run));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("irq", 32'(irq), 32'(|m_pend));
        chk("alarm_ch", 32'(alarm_ch), 32'(lowest(m_pend)));
        if (m_run && (m_cyc % R) < 2*N) begin
            k = (m_cyc % R) / 2;
            chk("cmp_sensor", 32'(cmp_sensor), 32'(sensor_bus[8*k +: 8]));
            chk("cmp_factory", 32'(cmp_factory), 32'(thr_of(k, factory_value)));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; scan_en = 1'b0; alarm_ack = 1'b0;
`ifdef FALL_THRESH_CFG_EN
        cfg_we = 1'b0; cfg_ch = 4'd0; cfg_data = 8'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic cfg_init();
`ifdef FALL_THRESH_CFG_EN
        for (int k = 0; k < N; k++) begin
            cfg_we = 1'b1; cfg_ch = 4'(k); cfg_data = E;
            tick();
        end
        cfg_we = 1'b0;
`endif
    endtask

    task automatic run_round(input logic [31:0] bus, input int ack_ph);
        sensor_bus = bus;
        for (int p = 0; p < R; p++) begin
            alarm_ack = (p == ack_ph);
            tick();
        end
        alarm_ack = 1'b0;
    endtask

    task automatic check_round(input string tag, input logic [3:0] p, input logic [3:0] a);
        chk({tag, "_pending"}, 32'(pending), 32'(p));
        chk({tag, "_irq"}, 32'(irq), 32'(|p));
        chk({tag, "_alarm_ch"}, 32'(alarm_ch), 32'(a));
    endtask

    task automatic add_row(input logic [7:0] c3, c2, c1, c0, input int ack_ph,
                           input logic [3:0] p, input logic [3:0] a);
        row_t r;
        r.bus = {c3, c2, c1, c0}; r.ack_ph = ack_ph; r.exp_pend = p; r.exp_ach = a;
        rows.push_back(r);
    endtask

    initial begin
        rst_n = 1'b0; scan_en = 1'b0; alarm_ack = 1'b0;
        sensor_bus = 32'h1122_3344; factory_value = E;
`ifdef FALL_THRESH_CFG_EN
        cfg_we = 1'b0; cfg_ch = 4'd0; cfg_data = 8'd0;
`endif
        // basic alarm on ch2
        add_row(L, H, L, L, -1, 4'b0000, 4'd0);
        add_row(L, H, L, L, -1, 4'b0000, 4'd0);
        add_row(L, H, L, L, -1, 4'b0100, 4'd2);
        add_row(L, L, L, L,  0, 4'b0000, 4'd0);
        // threshold boundary, no re-alarm while saturated, re-arm after a low round
        add_row(L, L, L, B, -1, 4'b0000, 4'd0);
        add_row(L, L, L, B, -1, 4'b0000, 4'd0);
        add_row(L, L, L, B, -1, 4'b0000, 4'd0);
        add_row(L, L, L, E, -1, 4'b0000, 4'd0);
        add_row(L, L, L, E, -1, 4'b0000, 4'd0);
        add_row(L, L, L, E, -1, 4'b0001, 4'd0);
        add_row(L, L, L, H,  0, 4'b0000, 4'd0);
        add_row(L, L, L, H, -1, 4'b0000, 4'd0);
        add_row(L, L, L, L, -1, 4'b0000, 4'd0);
        add_row(L, L, L, H, -1, 4'b0000, 4'd0);
        add_row(L, L, L, H, -1, 4'b0000, 4'd0);
        add_row(L, L, L, H, -1, 4'b0001, 4'd0);
        add_row(L, L, L, L,  0, 4'b0000, 4'd0);
        // debounce broken by one low sample
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, L, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0010, 4'd1);
        // two pending, acked lowest first
        add_row(H, L, H, L, -1, 4'b0010, 4'd1);
        add_row(H, L, H, L, -1, 4'b0010, 4'd1);
        add_row(H, L, H, L, -1, 4'b1010, 4'd1);
        add_row(H, L, H, L,  0, 4'b1000, 4'd3);
        add_row(H, L, H, L,  0, 4'b0000, 4'd0);
        // ack lands on the same edge as ch1's qualifying sample
        add_row(L, L, L, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0000, 4'd0);
        add_row(L, L, H, L, -1, 4'b0010, 4'd1);
        add_row(L, L, L, L, -1, 4'b0010, 4'd1);
        add_row(L, L, H, L, -1, 4'b0010, 4'd1);
        add_row(L, L, H, L, -1, 4'b0010, 4'd1);
        add_row(L, L, H, L,  3, 4'b0010, 4'd1);
        add_row(L, L, L, L,  0, 4'b0000, 4'd0);

        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_alarm_ch", 32'(alarm_ch), 32'd0);
        chk("rst_cmp_sensor", 32'(cmp_sensor), 32'h44);
`ifdef FALL_THRESH_CFG_EN
        chk("rst_cmp_factory", 32'(cmp_factory), 32'hFF);
`else
        chk("rst_cmp_factory", 32'(cmp_factory), 32'(E));
`endif
        cfg_init();

        sensor_bus = {L, L, L, L};
        scan_en = 1'b1;
        tick();
        foreach (rows[i]) begin
            run_round(rows[i].bus, rows[i].ack_ph);
            check_round($sformatf("row%0d", i), rows[i].exp_pend, rows[i].exp_ach);
        end

        // scan_en dropped during ch2 DRIVE: ch2 still sampled, count kept across IDLE
        sensor_bus = {L, H, L, L};
        repeat (4) tick();
        scan_en = 1'b0;
        tick();
        chk("drop_busy_sample", 32'(busy), 32'd1);
        tick();
        chk("drop_busy_idle", 32'(busy), 32'd0);
        repeat (3) tick();
        scan_en = 1'b1;
        tick();
        run_round({L, H, L, L}, -1);
        check_round("drop_r1", 4'b0000, 4'd0);
        run_round({L, H, L, L}, -1);
        check_round("drop_r2", 4'b0100, 4'd2);

        // asynchronous reset in the middle of GAP
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_pending", 32'(pending), 32'd0);
        chk("mrst_alarm_ch", 32'(alarm_ch), 32'd0);
        chk("mrst_cmp_sensor", 32'(cmp_sensor), 32'(L));
`ifdef FALL_THRESH_CFG_EN
        chk("mrst_cmp_factory", 32'(cmp_factory), 32'hFF);
`else
        chk("mrst_cmp_factory", 32'(cmp_factory), 32'(E));
`endif
        @(negedge clk);
        model_clear();
        scan_en = 1'b0;
        rst_n = 1'b1;
        tick();
        cfg_init();

        // randomized scan with random acks, scan_en drops and input changes between samples
        scan_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (!m_run || (m_cyc % R) >= 2*N) begin
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < N; k++) begin
                        sensor_bus[8*k +: 8] = ($urandom_range(0, 3) == 0) ? L : 8'(90 + $urandom_range(0, 20));
                    end
                    factory_value = 8'(96 + $urandom_range(0, 8));
                end
            end
            if (scan_en) scan_en = ($urandom_range(0, 199) != 0);
            else         scan_en = ($urandom_range(0, 4) == 0);
            alarm_ack = ($urandom_range(0, 5) == 0);
            tick();
        end
        alarm_ack = 1'b0;

`ifdef FALL_THRESH_CFG_EN
        // per-channel threshold overrides factory_value; out-of-range cfg_ch ignored
        do_reset();
        cfg_init();
        factory_value = 8'd200;
        sensor_bus = {8'd20, L, L, L};
        cfg_we = 1'b1; cfg_ch = 4'd3; cfg_data = 8'd10;
        tick();
        cfg_ch = 4'd9; cfg_data = 8'd0;
        tick();
        cfg_we = 1'b0;
        scan_en = 1'b1;
        tick();
        run_round({8'd20, L, L, L}, -1);
        check_round("cfg_r1", 4'b0000, 4'd0);
        run_round({8'd20, L, L, L}, -1);
        check_round("cfg_r2", 4'b0000, 4'd0);
        run_round({8'd20, L, L, L}, -1);
        check_round("cfg_r3", 4'b1000, 4'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
